memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- MEM stage of the 5-stage pipeline: takes the EX/MEM payload, issues load/store transactions on the data bus, aligns and extends load data, and produces the memory_data_t payload consumed by the MEM/WB register.
- Also produces Dwait and last_dataM, which the MEM/WB register uses to insert a bubble while a data access is outstanding.

Parameters:
- XLEN, 64, data/address width.
- RESET_PC, 64'h8000_0000, pc field of last_dataM after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset (asserted at 0)
- dataE_in  in  execute_data_t  EX/MEM payload: result = effective address, ctl.memread/ctl.memwrite/ctl.msize/ctl.msigned, rs2 store data, dst, pc, is_bubble
- stall_in  in  1  downstream/fetch stall (Iwait); the pipeline does not advance
- dreq  out  dbus_req_t  valid, addr, size, strobe, data
- dresp  in  dbus_resp_t  addr_ok, data_ok, data
- dataM_out  out  memory_data_t  combinational payload to MEM/WB
- last_dataM  out  memory_data_t  registered copy of the last payload that advanced
- Dwait  out  1  data access not yet complete; MEM/WB inserts a bubble

Behaviour:
- mem_op = !dataE_in.is_bubble && (ctl.memread || ctl.memwrite).
- FSM states:
  - IDLE: with mem_op, drive dreq.valid=1 this cycle. If dresp.data_ok arrives the same cycle: complete, go to HOLD when stall_in=1, else stay in IDLE. Without data_ok, go to REQ.
  - REQ: dreq.valid=1 with addr/size/strobe/data held stable. On data_ok: go to HOLD when stall_in=1, else go to IDLE.
  - HOLD: dreq.valid=0. Present the captured load data. Go to IDLE when stall_in=0.
- Only data_ok completes a transaction; addr_ok is ignored. Never re-issue in HOLD; exactly one transaction per mem instruction.
- Dwait = mem_op && state!=HOLD && !dresp.data_ok. Combinational. 0 for non-memory instructions.
- dreq.addr = {result[XLEN-1:3], 3'b0}. Offset o = result[2:0].
- Size encoding: msize 0/1/2/3 = byte/half/word/dword.
- dreq.strobe = (1,3,F,FF)[msize] << o on stores; 0 on loads.
- dreq.data = rs2 << (8*o).
- Load: raw = (data_ok ? dresp.data : captured) >> (8*o), truncated to the size. Sign-extend when msigned, else zero-extend.
- dataM_out:
  - pc/dst/ctl pass through.
  - result = extended load data for loads, else dataE_in.result.
  - is_bubble = dataE_in.is_bubble || Dwait.
- Captured data register loads on data_ok only.
- last_dataM <= dataM_out on every edge with Dwait=0 && stall_in=0; otherwise it holds.
- Reset (asynchronous, any state including mid-REQ):
  - state=IDLE, captured=0, dreq.valid=0 immediately.
  - last_dataM = {result 0, pc RESET_PC, ctl 0, dst 0, is_bubble 1}.
  - An abandoned transaction's late data_ok after reset release is ignored unless a new request is in flight.
- Simultaneous data_ok and stall_in=1 → HOLD; Dwait=0 that cycle.
- Reset has priority over every event.

Optional Feature:
- Macro: MEM_MISALIGN_EXC_EN.
- Defined:
  - Misaligned = o not a multiple of the access size.
  - A misaligned access issues no bus request; Dwait=0.
  - dataM_out.ctl.exception=1 with cause load/store-misaligned (5'd4 / 5'd6); result = address.
- Undefined: low offset bits are still applied (behaviour above); the exception field is tied 0.

Decomposition:
- Shared package pipes (existing file):
  - mem_state_t enum {IDLE, REQ, HOLD}
  - MSIZE_B/H/W/D constants
  - misaligned cause codes
- common: dbus_req_t, dbus_resp_t (existing).
- One sub-module: mem_align, purely combinational, covering strobe/data shift for stores and extract/extend for loads.

Test Plan:
- ld addr 0x8000_0010, data_ok after 3 cycles with data 0x1122_3344_5566_7788 → dreq.valid high 4 cycles, addr stable; Dwait=1 for 3 cycles; result=0x1122334455667788 with is_bubble=0 on the data_ok cycle.
- lb signed addr 0x...13, bus data 0x0000_0000_8000_0000 at byte3=0x80 → result=0xFFFF_FFFF_FFFF_FF80; lbu gives 0x80.
- sh addr 0x...06, rs2=0xABCD → strobe=0xC0, data=0xABCD_0000_0000_0000, single request; result=address.
- data_ok with stall_in=1 for 2 cycles → HOLD, dreq.valid=0, no second request, load result stable; IDLE after stall_in drops; last_dataM updates once.
- Reset asserted (reset=0) in REQ → dreq.valid=0 within the same cycle; last_dataM.pc=0x8000_0000, is_bubble=1; after release, a non-memory instruction gives Dwait=0.
- MEM_MISALIGN_EXC_EN: lw at 0x...02 → no dreq.valid, Dwait=0, exception=1, cause 4.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline payloads, data-bus structs and FSM states.
// MEM_MISALIGN_EXC_EN uses the misaligned cause codes defined here.
package memory_stage_pkg;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} mem_state_t;

    localparam logic [1:0] MSIZE_B = 2'd0;
    localparam logic [1:0] MSIZE_H = 2'd1;
    localparam logic [1:0] MSIZE_W = 2'd2;
    localparam logic [1:0] MSIZE_D = 2'd3;

    localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic [1:0] msize;
        logic       msigned;
        logic       exception;
        logic [4:0] cause;
    } control_t;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] rs2;
        logic [63:0] pc;
        logic [4:0]  dst;
        control_t    ctl;
        logic        is_bubble;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] pc;
        logic [4:0]  dst;
        control_t    ctl;
        logic        is_bubble;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Byte-lane mask of an access before it is shifted to its offset.
    function automatic logic [7:0] size_mask(input logic [1:0] msize);
        case (msize)
            MSIZE_B: size_mask = 8'h01;
            MSIZE_H: size_mask = 8'h03;
            MSIZE_W: size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Combinational lane steering: store strobe/data shift and load extract/extend.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [1:0]  msize_i,
    input  logic        msigned_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] store_data_i,
    input  logic [63:0] load_data_i,
    output logic [7:0]  strobe_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);
    logic [5:0]  shamt;
    logic [63:0] raw;

    always_comb begin
        shamt    = {offset_i, 3'b000};
        strobe_o = size_mask(msize_i) << offset_i;
        wdata_o  = store_data_i << shamt;
        raw      = load_data_i >> shamt;
        case (msize_i)
            MSIZE_B: rdata_o = msigned_i ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            MSIZE_H: rdata_o = msigned_i ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            MSIZE_W: rdata_o = msigned_i ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: rdata_o = raw;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: one data-bus transaction per memory instruction, load alignment,
// Dwait bubble request. Define MEM_MISALIGN_EXC_EN to trap misaligned accesses.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE_in,
    input  logic          stall_in,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM_out,
    output memory_data_t  last_dataM,
    output logic          Dwait
);
    mem_state_t   state_q, state_d;
    logic [63:0]  capt_q;
    memory_data_t last_q;

    logic        mem_op, misaligned, bus_op, resp_ok;
    logic [2:0]  offset;
    logic [7:0]  align_strobe;
    logic [63:0] align_wdata, load_ext;
    logic        unused_addr_ok;

    assign unused_addr_ok = dresp.addr_ok;
    assign offset = dataE_in.result[2:0];
    assign mem_op = !dataE_in.is_bubble && (dataE_in.ctl.memread || dataE_in.ctl.memwrite);

`ifdef MEM_MISALIGN_EXC_EN
    always_comb begin
        case (dataE_in.ctl.msize)
            MSIZE_B: misaligned = 1'b0;
            MSIZE_H: misaligned = offset[0];
            MSIZE_W: misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign bus_op  = mem_op && !misaligned;
    // Gating with the live request keeps a stale data_ok from an abandoned access harmless.
    assign resp_ok = dreq.valid && dresp.data_ok;
    assign Dwait   = bus_op && (state_q != HOLD) && !resp_ok;

    mem_align u_align (
        .msize_i      (dataE_in.ctl.msize),
        .msigned_i    (dataE_in.ctl.msigned),
        .offset_i     (offset),
        .store_data_i (dataE_in.rs2),
        .load_data_i  (resp_ok ? dresp.data : capt_q),
        .strobe_o     (align_strobe),
        .wdata_o      (align_wdata),
        .rdata_o      (load_ext)
    );

    always_comb begin
        dreq        = '0;
        dreq.valid  = reset && bus_op && (state_q != HOLD);
        dreq.addr   = {dataE_in.result[XLEN-1:3], 3'b000};
        dreq.size   = dataE_in.ctl.msize;
        dreq.strobe = dataE_in.ctl.memwrite ? align_strobe : 8'h00;
        dreq.data   = align_wdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus_op) state_d = resp_ok ? (stall_in ? HOLD : IDLE) : REQ;
            REQ:  if (resp_ok) state_d = stall_in ? HOLD : IDLE;
            HOLD: if (!stall_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dataM_out               = '0;
        dataM_out.pc            = dataE_in.pc;
        dataM_out.dst           = dataE_in.dst;
        dataM_out.ctl           = dataE_in.ctl;
        dataM_out.ctl.exception = 1'b0;
        dataM_out.result        = dataE_in.ctl.memread ? load_ext : dataE_in.result;
        dataM_out.is_bubble     = dataE_in.is_bubble || Dwait;
`ifdef MEM_MISALIGN_EXC_EN
        if (mem_op && misaligned) begin
            dataM_out.ctl.exception = 1'b1;
            dataM_out.ctl.cause     = dataE_in.ctl.memread ? CAUSE_LOAD_MISALIGNED
                                                           : CAUSE_STORE_MISALIGNED;
            dataM_out.result        = dataE_in.result;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            capt_q           <= '0;
            last_q           <= '0;
            last_q.pc        <= RESET_PC;
            last_q.is_bubble <= 1'b1;
        end else begin
            state_q <= state_d;
            if (resp_ok) capt_q <= dresp.data;
            if (!Dwait && !stall_in) last_q <= dataM_out;
        end
    end

    assign last_dataM = last_q;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed loads/stores, stalls, reset mid-request.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE_in;
    logic          stall_in;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM_out, last_dataM;
    logic          Dwait;

    memory_stage dut (
        .clk        (clk),
        .reset      (reset),
        .dataE_in   (dataE_in),
        .stall_in   (stall_in),
        .dreq       (dreq),
        .dresp      (dresp),
        .dataM_out  (dataM_out),
        .last_dataM (last_dataM),
        .Dwait      (Dwait)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] result;
        int          nv;
        int          nw;
        logic        exc;
        logic [4:0]  cause;
    } exp_t;

    typedef struct {
        string       tag;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] data;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic execute_data_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                         input logic sg, input logic [63:0] addr,
                                         input logic [63:0] rs2);
        execute_data_t e;
        e = '0;
        e.ctl.memread  = rd;
        e.ctl.memwrite = wr;
        e.ctl.msize    = sz;
        e.ctl.msigned  = sg;
        e.result       = addr;
        e.rs2          = rs2;
        e.pc           = 64'h8000_1000;
        e.dst          = 5'd7;
        return e;
    endfunction

    // Monitor: counts bus/Dwait cycles per instruction, checks each new request and each
    // payload that advances against the queues filled by the stimulus.
    initial begin : monitor
        int   cnt_v, cnt_w;
        logic prev_valid, prev_ok;
        exp_t x;
        req_t r;
        cnt_v = 0; cnt_w = 0; prev_valid = 1'b0; prev_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt_v = 0; cnt_w = 0; prev_valid = 1'b0; prev_ok = 1'b0;
            end else begin
                if (dreq.valid) cnt_v++;
                if (Dwait) cnt_w++;
                if (dreq.valid && !(prev_valid && !prev_ok)) begin
                    if (req_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_req: got addr %h expected no request", dreq.addr);
                    end else begin
                        r = req_q.pop_front();
                        chk({r.tag, "_addr"}, dreq.addr, r.addr);
                        chk({r.tag, "_strobe"}, {56'd0, dreq.strobe}, {56'd0, r.strb});
                        chk({r.tag, "_wdata"}, dreq.data, r.data);
                    end
                end
                prev_valid = dreq.valid;
                prev_ok    = dresp.data_ok;
                if (!dataM_out.is_bubble) begin
                    if (stall_in) begin
                        if (exp_q.size() > 0)
                            chk({exp_q[0].tag, "_stalled_result"}, dataM_out.result, exp_q[0].result);
                    end else if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_out: got result %h expected none", dataM_out.result);
                    end else begin
                        x = exp_q.pop_front();
                        chk({x.tag, "_result"}, dataM_out.result, x.result);
                        chk({x.tag, "_nvalid"}, 64'(cnt_v), 64'(x.nv));
                        chk({x.tag, "_ndwait"}, 64'(cnt_w), 64'(x.nw));
                        chk({x.tag, "_exc"}, {63'd0, dataM_out.ctl.exception}, {63'd0, x.exc});
                        if (x.exc) chk({x.tag, "_cause"}, {59'd0, dataM_out.ctl.cause}, {59'd0, x.cause});
                        cnt_v = 0; cnt_w = 0;
                    end
                end
            end
        end
    end

    // lat<0: no data_ok driven. nstall: cycles stall_in stays high from the data_ok cycle.
    task automatic do_op(input string tag, input execute_data_t e, input int lat,
                         input logic [63:0] bdata, input int nstall, input logic [63:0] exp_res,
                         input int nv, input int nw, input logic exc, input logic [4:0] cause,
                         input logic [63:0] hold_last, input logic [63:0] exp_addr,
                         input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
        exp_t x;
        req_t r;
        x.tag = tag; x.result = exp_res; x.nv = nv; x.nw = nw; x.exc = exc; x.cause = cause;
        exp_q.push_back(x);
        if (nv > 0) begin
            r.tag = tag; r.addr = exp_addr; r.strb = exp_strb; r.data = exp_wdata;
            req_q.push_back(r);
        end
        dataE_in = e; stall_in = 1'b0; dresp = '0;
        if (lat >= 0) begin
            for (int k = 0; k < lat; k++) begin @(posedge clk); #1; end
            dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = bdata;
            stall_in = (nstall > 0);
        end
        @(posedge clk); #1;
        dresp = '0;
        if (nstall > 0) begin
            chk({tag, "_last_hold"}, last_dataM.result, hold_last);
            for (int s = 1; s < nstall; s++) begin
                @(posedge clk); #1;
                chk({tag, "_last_hold"}, last_dataM.result, hold_last);
            end
            stall_in = 1'b0;
            @(posedge clk); #1;
        end
        chk({tag, "_last"}, last_dataM.result, exp_res);
    endtask

    initial begin : stimulus
        execute_data_t bub;
        bub = '0;
        bub.is_bubble = 1'b1;
        reset = 1'b0; dataE_in = bub; stall_in = 1'b0; dresp = '0;
        @(posedge clk); #1;
        chk("rst_last_pc", last_dataM.pc, 64'h8000_0000);
        chk("rst_last_bubble", {63'd0, last_dataM.is_bubble}, 64'd1);
        chk("rst_valid", {63'd0, dreq.valid}, 64'd0);
        chk("rst_dwait", {63'd0, Dwait}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        do_op("ld", mk(1, 0, MSIZE_D, 1, 64'h8000_0010, 0), 3, 64'h1122_3344_5566_7788, 0,
              64'h1122_3344_5566_7788, 4, 3, 0, 0, 0, 64'h8000_0010, 8'h00, 64'h0);
        do_op("lb", mk(1, 0, MSIZE_B, 1, 64'h8000_0013, 0), 0, 64'h0000_0000_8000_0000, 0,
              64'hFFFF_FFFF_FFFF_FF80, 1, 0, 0, 0, 0, 64'h8000_0010, 8'h00, 64'h0);
        do_op("lbu", mk(1, 0, MSIZE_B, 0, 64'h8000_0013, 0), 1, 64'h0000_0000_8000_0000, 0,
              64'h80, 2, 1, 0, 0, 0, 64'h8000_0010, 8'h00, 64'h0);
        do_op("sh", mk(0, 1, MSIZE_H, 0, 64'h8000_0006, 64'hABCD), 2, 64'h0, 0,
              64'h8000_0006, 3, 2, 0, 0, 0, 64'h8000_0000, 8'hC0, 64'hABCD_0000_0000_0000);
        do_op("lh", mk(1, 0, MSIZE_H, 1, 64'h8000_000E, 0), 0, 64'h8001_0000_0000_0000, 0,
              64'hFFFF_FFFF_FFFF_8001, 1, 0, 0, 0, 0, 64'h8000_0008, 8'h00, 64'h0);
        do_op("sb", mk(0, 1, MSIZE_B, 0, 64'h8000_0017, 64'hAA), 0, 64'h0, 0,
              64'h8000_0017, 1, 0, 0, 0, 0, 64'h8000_0010, 8'h80, 64'hAA00_0000_0000_0000);
        do_op("sd", mk(0, 1, MSIZE_D, 0, 64'h8000_0018, 64'h0102_0304_0506_0708), 1, 64'h0, 0,
              64'h8000_0018, 2, 1, 0, 0, 0, 64'h8000_0018, 8'hFF, 64'h0102_0304_0506_0708);
        do_op("alu", mk(0, 0, MSIZE_D, 0, 64'h1234, 0), -1, 64'h0, 0,
              64'h1234, 0, 0, 0, 0, 0, 64'h0, 8'h00, 64'h0);
        do_op("lw_stall", mk(1, 0, MSIZE_W, 1, 64'h8000_0024, 0), 1, 64'hDEAD_BEEF_0000_0000, 2,
              64'hFFFF_FFFF_DEAD_BEEF, 2, 1, 0, 0, 64'h1234, 64'h8000_0020, 8'h00, 64'h0);

        begin : reset_mid_req
            req_t r;
            r.tag = "ld_abort"; r.addr = 64'h8000_0040; r.strb = 8'h00; r.data = 64'h0;
            req_q.push_back(r);
            dataE_in = mk(1, 0, MSIZE_D, 0, 64'h8000_0040, 0);
            dresp = '0; stall_in = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #2;
            reset = 1'b0;
            #1;
            chk("rst_req_valid", {63'd0, dreq.valid}, 64'd0);
            chk("rst_req_last_pc", last_dataM.pc, 64'h8000_0000);
            chk("rst_req_last_bubble", {63'd0, last_dataM.is_bubble}, 64'd1);
            chk("rst_req_last_result", last_dataM.result, 64'h0);
            dataE_in = bub;
            @(posedge clk); #1;
            reset = 1'b1;
            dresp.data_ok = 1'b1; dresp.data = '1;
            @(posedge clk); #1;
            dresp = '0;
        end

        do_op("alu_post", mk(0, 0, MSIZE_D, 0, 64'h55, 0), -1, 64'h0, 0,
              64'h55, 0, 0, 0, 0, 0, 64'h0, 8'h00, 64'h0);
        do_op("ld_post", mk(1, 0, MSIZE_D, 0, 64'h8000_0040, 0), 1, 64'h0F0E_0D0C_0B0A_0908, 0,
              64'h0F0E_0D0C_0B0A_0908, 2, 1, 0, 0, 0, 64'h8000_0040, 8'h00, 64'h0);
`ifdef MEM_MISALIGN_EXC_EN
        do_op("lw_mis", mk(1, 0, MSIZE_W, 1, 64'h8000_0002, 0), -1, 64'h0, 0,
              64'h8000_0002, 0, 0, 1, 5'd4, 0, 64'h0, 8'h00, 64'h0);
        do_op("sw_mis", mk(0, 1, MSIZE_W, 0, 64'h8000_0001, 64'h77), -1, 64'h0, 0,
              64'h8000_0001, 0, 0, 1, 5'd6, 0, 64'h0, 8'h00, 64'h0);
`endif
        dataE_in = bub;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("exp_left", 64'(exp_q.size()), 64'd0);
        chk("req_left", 64'(req_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
